// File: rtl/io_port_bridge_if.sv
// Processor/device signal bundle for io_port_bridge.
// Defining IO_OUT_STALL_EN adds the io_stall output.
interface io_port_bridge_if #(
    parameter int DATA_W = 16
);
    logic              out_wr_en;
    logic [DATA_W-1:0] out_wr_data;
    logic              in_rd_en;
    logic [DATA_W-1:0] in_port_data;
    logic              in_port_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              clr_flags;
    logic              out_overflow;
    logic              in_underflow;
`ifdef IO_OUT_STALL_EN
    logic              io_stall;

    modport slave (
        input  out_wr_en, out_wr_data, in_rd_en, tx_ready, rx_data, rx_valid, clr_flags,
        output in_port_data, in_port_valid, tx_data, tx_valid, rx_ready,
               out_overflow, in_underflow, io_stall
    );

    modport master (
        output out_wr_en, out_wr_data, in_rd_en, tx_ready, rx_data, rx_valid, clr_flags,
        input  in_port_data, in_port_valid, tx_data, tx_valid, rx_ready,
               out_overflow, in_underflow, io_stall
    );
`else
    modport slave (
        input  out_wr_en, out_wr_data, in_rd_en, tx_ready, rx_data, rx_valid, clr_flags,
        output in_port_data, in_port_valid, tx_data, tx_valid, rx_ready,
               out_overflow, in_underflow
    );

    modport master (
        output out_wr_en, out_wr_data, in_rd_en, tx_ready, rx_data, rx_valid, clr_flags,
        input  in_port_data, in_port_valid, tx_data, tx_valid, rx_ready,
               out_overflow, in_underflow
    );
`endif
endinterface

// File: rtl/io_port_bridge.sv
// TX/RX FIFO bridge between processor OUT/IN instructions and a valid/ready device.
// IO_OUT_STALL_EN: stall OUT via io_stall instead of dropping words on a full TX FIFO.
module io_port_bridge #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    io_port_bridge_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_tx_mem [DEPTH];
    logic [PTR_W-1:0]  r_tx_wr_ptr;
    logic [PTR_W-1:0]  r_tx_rd_ptr;
    logic [CNT_W-1:0]  r_tx_count;

    logic [DATA_W-1:0] r_rx_mem [DEPTH];
    logic [PTR_W-1:0]  r_rx_wr_ptr;
    logic [PTR_W-1:0]  r_rx_rd_ptr;
    logic [CNT_W-1:0]  r_rx_count;

    logic r_in_underflow;

    logic w_tx_valid;
    logic w_tx_full;
    logic w_tx_pop;
    logic w_tx_push;
    logic w_rx_valid;
    logic w_rx_ready;
    logic w_rx_pop;
    logic w_rx_push;
    logic w_underflow_set;

    assign w_tx_valid = (r_tx_count != '0);
    assign w_tx_full  = (r_tx_count == C_FULL);
    assign w_tx_pop   = w_tx_valid && bus.tx_ready;
    // A full FIFO still accepts a word when its head leaves in the same cycle.
    assign w_tx_push  = bus.out_wr_en && (!w_tx_full || w_tx_pop);

    assign w_rx_valid = (r_rx_count != '0);
    assign w_rx_ready = rst && (r_rx_count != C_FULL);
    assign w_rx_push  = bus.rx_valid && w_rx_ready;
    assign w_rx_pop   = bus.in_rd_en && w_rx_valid;
    assign w_underflow_set = bus.in_rd_en && !w_rx_valid;

    assign bus.tx_valid      = w_tx_valid;
    assign bus.tx_data       = w_tx_valid ? r_tx_mem[r_tx_rd_ptr] : '0;
    assign bus.in_port_valid = w_rx_valid;
    assign bus.in_port_data  = w_rx_valid ? r_rx_mem[r_rx_rd_ptr] : '0;
    assign bus.rx_ready      = w_rx_ready;
    assign bus.in_underflow  = r_in_underflow;

`ifdef IO_OUT_STALL_EN
    assign bus.io_stall     = w_tx_full && !w_tx_pop;
    assign bus.out_overflow = 1'b0;
`else
    logic r_out_overflow;
    logic w_overflow_set;

    assign w_overflow_set   = bus.out_wr_en && w_tx_full && !w_tx_pop;
    assign bus.out_overflow = r_out_overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_overflow <= 1'b0;
        end else if (w_overflow_set) begin
            r_out_overflow <= 1'b1;
        end else if (bus.clr_flags) begin
            r_out_overflow <= 1'b0;
        end
    end
`endif

    // Storage carries no reset; validity comes solely from the counts.
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= bus.out_wr_data;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_wr_ptr    <= '0;
            r_tx_rd_ptr    <= '0;
            r_tx_count     <= '0;
            r_rx_wr_ptr    <= '0;
            r_rx_rd_ptr    <= '0;
            r_rx_count     <= '0;
            r_in_underflow <= 1'b0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + PTR_W'(1);
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + PTR_W'(1);
            end
            if (w_tx_push && !w_tx_pop) begin
                r_tx_count <= r_tx_count + CNT_W'(1);
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_count <= r_tx_count - CNT_W'(1);
            end

            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + PTR_W'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + PTR_W'(1);
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_count <= r_rx_count + CNT_W'(1);
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_count <= r_rx_count - CNT_W'(1);
            end

            if (w_underflow_set) begin
                r_in_underflow <= 1'b1;
            end else if (bus.clr_flags) begin
                r_in_underflow <= 1'b0;
            end
        end
    end
endmodule
